// File: rtl/serial_parity_rx.sv
// serial_parity_rx: start/data(LSB first)/parity/stop frame receiver with XOR parity and framing checks
module serial_parity_rx #(
  parameter int DATA_W     = 8,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_en,
  input  logic              rx,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);
  localparam int CW = $clog2(DATA_W) + 1;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d, data_q, data_d;
  logic              par_q, par_d, mis_q, mis_d;
  logic              valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d, busy_q, busy_d;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    par_d   = par_q;
    mis_d   = mis_q;
    valid_d = 1'b0;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;
    if (bit_en) begin
      case (state_q)
        IDLE: if (!rx) begin
          state_d = DATA;
          cnt_d   = '0;
          par_d   = 1'b0;
        end
        DATA: begin
          // concatenate-and-shift keeps DATA_W=1 legal
          shift_d = DATA_W'({rx, shift_q} >> 1);
          par_d   = par_q ^ rx;
          cnt_d   = cnt_q + CW'(1);
          state_d = (cnt_q == CW'(DATA_W - 1)) ? PARITY : DATA;
        end
        PARITY: begin
          mis_d   = rx ^ par_q ^ PARITY_ODD;
          state_d = STOP;
        end
        default: begin
          data_d  = rx ? shift_q : data_q;
          valid_d = rx;
          perr_d  = rx & mis_q;
          ferr_d  = !rx;
          state_d = IDLE;
        end
      endcase
    end
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      par_q   <= 1'b0;
      mis_q   <= 1'b0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      par_q   <= par_d;
      mis_q   <= mis_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
    end
  end
  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign busy       = busy_q;
endmodule

// File: tb/tb_serial_parity_rx.sv
// tb_serial_parity_rx: even- and odd-parity receivers fed the same line, checked against a frame-level model
module tb_serial_parity_rx;
  localparam int DATA_W = 8;
  localparam int FLEN   = DATA_W + 3;
  logic clk = 1'b0;
  logic rst, bit_en, rx;
  logic [DATA_W-1:0] data_e, data_o;
  logic dv_e, pe_e, fe_e, bz_e, dv_o, pe_o, fe_o, bz_o;
  int checks = 0;
  int passes = 0;
  serial_parity_rx #(.DATA_W(DATA_W), .PARITY_ODD(1'b0)) dut_e (
    .clk(clk), .rst(rst), .bit_en(bit_en), .rx(rx), .data_out(data_e),
    .data_valid(dv_e), .parity_err(pe_e), .frame_err(fe_e), .busy(bz_e));
  serial_parity_rx #(.DATA_W(DATA_W), .PARITY_ODD(1'b1)) dut_o (
    .clk(clk), .rst(rst), .bit_en(bit_en), .rx(rx), .data_out(data_o),
    .data_valid(dv_o), .parity_err(pe_o), .frame_err(fe_o), .busy(bz_o));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else passes++;
  endtask
  // frame-level model: collect the sampled bits of a frame, judge it once complete
  logic [FLEN-1:0]   fr;
  logic [DATA_W-1:0] ed, dw;
  logic ev, ep_e, ep_o, ef, eb;
  int n;
  initial begin
    fr = '0; ed = '0; ev = 0; ep_e = 0; ep_o = 0; ef = 0; eb = 0; n = 0;
  end
  always @(negedge clk) begin
    chk("data_e", 32'(data_e), 32'(ed));
    chk("valid_e", 32'(dv_e), 32'(ev));
    chk("perr_e", 32'(pe_e), 32'(ep_e));
    chk("ferr_e", 32'(fe_e), 32'(ef));
    chk("busy_e", 32'(bz_e), 32'(eb));
    chk("data_o", 32'(data_o), 32'(ed));
    chk("valid_o", 32'(dv_o), 32'(ev));
    chk("perr_o", 32'(pe_o), 32'(ep_o));
    chk("ferr_o", 32'(fe_o), 32'(ef));
    chk("busy_o", 32'(bz_o), 32'(eb));
    ev = 0; ep_e = 0; ep_o = 0; ef = 0;
    if (rst) begin
      n = 0; ed = '0;
    end else if (bit_en) begin
      if (n == 0) begin
        if (!rx) begin fr = '0; n = 1; end
      end else begin
        fr[n] = rx;
        n++;
        if (n == FLEN) begin
          dw = fr[DATA_W:1];
          if (rx) begin
            ed = dw; ev = 1;
            ep_e = ^dw ^ fr[DATA_W+1];
            ep_o = ~(^dw ^ fr[DATA_W+1]);
          end else ef = 1;
          n = 0;
        end
      end
    end
    eb = n != 0;
  end
  task automatic strobe(input logic b, input int gap);
    repeat (gap) begin
      bit_en = 0; rx = 1'($urandom); @(posedge clk); #1;
    end
    bit_en = 1; rx = b; @(posedge clk); #1;
    bit_en = 0; rx = 1;
  endtask
  task automatic send_frame(input logic [DATA_W-1:0] d, input logic p, input logic stop, input int gap);
    strobe(1'b0, gap);
    for (int i = 0; i < DATA_W; i++) strobe(d[i], gap);
    strobe(p, gap);
    strobe(stop, gap);
  endtask
  task automatic pulse_rst;
    rst = 1; bit_en = 1'($urandom); rx = 1'($urandom); @(posedge clk); #1;
    rst = 0; bit_en = 0; rx = 1;
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end, got timeout required finish");
    $fatal(1);
  end
  initial begin
    rst = 1; bit_en = 1; rx = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data", 32'(data_e), 32'h0);
    chk("rst_busy", 32'(bz_e), 32'h0);
    chk("rst_valid", 32'(dv_o), 32'h0);
    rst = 0;
    send_frame(8'hA5, 1'b0, 1'b1, 0);
    chk("a5_data", 32'(data_e), 32'hA5);
    chk("a5_valid", 32'(dv_e), 32'h1);
    chk("a5_perr_even", 32'(pe_e), 32'h0);
    chk("a5_perr_odd", 32'(pe_o), 32'h1);
    chk("a5_ferr", 32'(fe_e), 32'h0);
    send_frame(8'hA5, 1'b1, 1'b1, 0);
    chk("a5p1_perr_even", 32'(pe_e), 32'h1);
    chk("a5p1_perr_odd", 32'(pe_o), 32'h0);
    send_frame(8'h3C, 1'b0, 1'b0, 0);
    chk("3c_ferr", 32'(fe_e), 32'h1);
    chk("3c_valid", 32'(dv_e), 32'h0);
    chk("3c_data_held", 32'(data_e), 32'hA5);
    @(posedge clk); #1;
    chk("3c_ferr_drop", 32'(fe_e), 32'h0);
    send_frame(8'hFF, 1'b0, 1'b1, 2);
    chk("ff_data", 32'(data_e), 32'hFF);
    chk("ff_perr", 32'(pe_e), 32'h0);
    send_frame(8'h01, 1'b1, 1'b1, 2);
    chk("01_data", 32'(data_e), 32'h01);
    chk("01_valid", 32'(dv_e), 32'h1);
    chk("01_perr", 32'(pe_e), 32'h0);
    strobe(1'b0, 0);
    for (int i = 0; i < 4; i++) strobe(1'(8'h5A >> i), 0);
    pulse_rst();
    chk("abort_busy", 32'(bz_e), 32'h0);
    chk("abort_data", 32'(data_e), 32'h0);
    send_frame(8'h0F, 1'b0, 1'b1, 0);
    chk("0f_data", 32'(data_e), 32'h0F);
    chk("0f_perr", 32'(pe_e), 32'h0);
    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        strobe(1'b0, $urandom_range(0, 2));
        repeat ($urandom_range(0, DATA_W + 1)) strobe(1'($urandom), $urandom_range(0, 2));
        pulse_rst();
      end
      repeat ($urandom_range(0, 2)) strobe(1'b1, $urandom_range(0, 2));
      send_frame(DATA_W'($urandom), 1'($urandom), $urandom_range(0, 7) != 0, $urandom_range(0, 2));
    end
    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
